// File: rtl/hw_stack.sv
`default_nettype none
// ============================================================================
//  Module   : hw_stack
//  Purpose  : LIFO data stack for the 16-bit single-cycle processor. Push and
//             pop strobes come from the control decoder. The top-of-stack word
//             is presented combinationally so the register file can capture it
//             on the same edge that decrements the pointer.
//  Ports    : clk        - system clock, rising edge active
//             rst_n      - asynchronous active-low reset
//             stack_en   - stack operation strobe
//             stack_rwb  - 1 = pop, 0 = push (ignored when stack_en = 0)
//             push_data  - word to push
//             err_clr    - synchronous clear of the sticky error flags
//             pop_data   - current top-of-stack word, 0 when empty
//             sp         - stack pointer (number of valid entries, 0..DEPTH)
//             empty/full - sp == 0 / sp == DEPTH
//             overflow   - sticky: push attempted while full
//             underflow  - sticky: pop attempted while empty
//  Revision : 1.0 - initial release
// ============================================================================
module hw_stack #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stack_en,
    input  logic             stack_rwb,
    input  logic [WIDTH-1:0] push_data,
    input  logic             err_clr,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      sp,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] c_one   = (AW+1)'(1);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_sp;
    logic             r_ovf;
    logic             r_unf;

    logic             w_empty;
    logic             w_full;
    logic             w_push_req;
    logic             w_pop_req;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_push_err;
    logic             w_pop_err;
    logic [AW-1:0]    w_top_idx;

    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == c_depth);

    // stack_rwb only matters when stack_en is high, so X on it while idle
    // is masked here.
    assign w_push_req = stack_en & ~stack_rwb;
    assign w_pop_req  = stack_en &  stack_rwb;
    assign w_push_ok  = w_push_req & ~w_full;
    assign w_pop_ok   = w_pop_req  & ~w_empty;
    assign w_push_err = w_push_req &  w_full;
    assign w_pop_err  = w_pop_req  &  w_empty;

    // sp-1 always fits in AW bits whenever the stack is non-empty; the
    // empty case is masked out below.
    assign w_top_idx  = AW'(r_sp - c_one);
    assign pop_data   = w_empty ? '0 : r_mem[w_top_idx];

    // Memory writes sit inside the reset-qualified block so that a push
    // coinciding with an asserted reset is discarded. The array itself is
    // intentionally not cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_sp[AW-1:0]] <= push_data;
                r_sp                <= r_sp + c_one;
            end else if (w_pop_ok) begin
                r_sp <= r_sp - c_one;
            end

            // A new error takes priority over a coincident clear.
            if (w_push_err) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end

            if (w_pop_err) begin
                r_unf <= 1'b1;
            end else if (err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign sp        = r_sp;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_hw_stack.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_hw_stack
//  Purpose  : Self-checking bench for hw_stack. Stimulus queues the expected
//             post-edge state; a monitor compares it on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hw_stack;

    logic        clk;
    logic        rst_n;
    logic        stack_en;
    logic        stack_rwb;
    logic [15:0] push_data;
    logic        err_clr;
    logic [15:0] pop_data;
    logic [4:0]  sp;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    hw_stack #(.WIDTH(16), .DEPTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stack_en  (stack_en),
        .stack_rwb (stack_rwb),
        .push_data (push_data),
        .err_clr   (err_clr),
        .pop_data  (pop_data),
        .sp        (sp),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    typedef struct {
        int          cyc;
        int          id;
        logic [4:0]  sp;
        logic [15:0] pd;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_id = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares queued expectations on the falling edge.
    initial begin
        exp_t e;
        logic [23:0] got;
        logic [23:0] want;
        forever begin
            @(negedge clk);
            cyc++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e    = q.pop_front();
                got  = {sp, pop_data, empty, full, overflow, underflow};
                want = {e.sp, e.pd, (e.sp == 5'd0), (e.sp == 5'd16), e.ovf, e.unf};
                n_tests++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL step%0d: got sp=%0d pd=%h empty=%b full=%b ovf=%b unf=%b, want sp=%0d pd=%h empty=%b full=%b ovf=%b unf=%b",
                             e.id, sp, pop_data, empty, full, overflow, underflow,
                             e.sp, e.pd, (e.sp == 5'd0), (e.sp == 5'd16), e.ovf, e.unf);
                end
            end
        end
    end

    // Drive one cycle and queue the state expected after the next rising edge.
    task automatic op(input logic en, input logic rwb, input logic [15:0] d,
                      input logic clr, input int esp, input logic [15:0] epd,
                      input logic eov, input logic eun);
        exp_t e;
        stack_en  = en;
        stack_rwb = rwb;
        push_data = d;
        err_clr   = clr;
        step_id++;
        e.cyc = cyc + 1;
        e.id  = step_id;
        e.sp  = 5'(esp);
        e.pd  = epd;
        e.ovf = eov;
        e.unf = eun;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b1;
        stack_en  = 1'b0;
        stack_rwb = 1'b0;
        push_data = 16'h0;
        err_clr   = 1'b0;
        #1 rst_n  = 1'b0;
        @(negedge clk);
        #1;

        // Reset held while the strobe toggles.
        op(1'b1, 1'b0, 16'hAAAA, 1'b0, 0, 16'h0000, 1'b0, 1'b0);
        op(1'b0, 1'b0, 16'h5555, 1'b0, 0, 16'h0000, 1'b0, 1'b0);
        op(1'b1, 1'b1, 16'h1111, 1'b0, 0, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        // LIFO order
        op(1'b1, 1'b0, 16'h1234, 1'b0, 1, 16'h1234, 1'b0, 1'b0);
        op(1'b1, 1'b0, 16'hBEEF, 1'b0, 2, 16'hBEEF, 1'b0, 1'b0);
        op(1'b1, 1'b0, 16'h0001, 1'b0, 3, 16'h0001, 1'b0, 1'b0);
        op(1'b1, 1'b1, 16'h0000, 1'b0, 2, 16'hBEEF, 1'b0, 1'b0);
        op(1'b1, 1'b1, 16'h0000, 1'b0, 1, 16'h1234, 1'b0, 1'b0);
        op(1'b1, 1'b1, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b0);

        // Fill to the boundary, then one push too many.
        for (int i = 0; i < 16; i++)
            op(1'b1, 1'b0, 16'(i), 1'b0, i + 1, 16'(i), 1'b0, 1'b0);
        op(1'b1, 1'b0, 16'hFFFF, 1'b0, 16, 16'h000F, 1'b1, 1'b0);
        op(1'b0, 1'b0, 16'h0000, 1'b1, 16, 16'h000F, 1'b0, 1'b0);

        // Drain: after k+1 pops, sp = 15-k and top holds value sp-1.
        for (int k = 0; k < 16; k++)
            op(1'b1, 1'b1, 16'h0000, 1'b0, 15 - k,
               (k == 15) ? 16'h0000 : 16'(14 - k), 1'b0, 1'b0);

        // Underflow, clear, clear racing a new error.
        op(1'b1, 1'b1, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b1);
        op(1'b0, 1'b0, 16'h0000, 1'b1, 0, 16'h0000, 1'b0, 1'b0);
        op(1'b1, 1'b1, 16'h0000, 1'b1, 0, 16'h0000, 1'b0, 1'b1);
        op(1'b0, 1'b0, 16'h0000, 1'b1, 0, 16'h0000, 1'b0, 1'b0);

        // Interleaved push/pop, then idle with stack_rwb unknown.
        op(1'b1, 1'b0, 16'h00A0, 1'b0, 1, 16'h00A0, 1'b0, 1'b0);
        op(1'b1, 1'b1, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b0);
        op(1'b1, 1'b0, 16'h00B0, 1'b0, 1, 16'h00B0, 1'b0, 1'b0);
        op(1'b1, 1'b0, 16'h00C0, 1'b0, 2, 16'h00C0, 1'b0, 1'b0);
        op(1'b1, 1'b1, 16'h0000, 1'b0, 1, 16'h00B0, 1'b0, 1'b0);
        op(1'b0, 1'bx, 16'hDEAD, 1'b0, 1, 16'h00B0, 1'b0, 1'b0);
        op(1'b0, 1'bx, 16'hBEEF, 1'b0, 1, 16'h00B0, 1'b0, 1'b0);

        // Build up to sp = 5.
        op(1'b1, 1'b0, 16'h0011, 1'b0, 2, 16'h0011, 1'b0, 1'b0);
        op(1'b1, 1'b0, 16'h0022, 1'b0, 3, 16'h0022, 1'b0, 1'b0);
        op(1'b1, 1'b0, 16'h0033, 1'b0, 4, 16'h0033, 1'b0, 1'b0);
        op(1'b1, 1'b0, 16'h0044, 1'b0, 5, 16'h0044, 1'b0, 1'b0);

        // Async reset between edges: asserted after a rising edge and
        // checked at the following falling edge, with no rising edge between.
        begin
            exp_t e;
            stack_en  = 1'b0;
            stack_rwb = 1'b0;
            err_clr   = 1'b0;
            step_id++;
            e.cyc = cyc + 1;
            e.id  = step_id;
            e.sp  = 5'd0;
            e.pd  = 16'h0000;
            e.ovf = 1'b0;
            e.unf = 1'b0;
            q.push_back(e);
            @(posedge clk);
            #2 rst_n = 1'b0;
            @(negedge clk);
            #1 rst_n = 1'b1;
        end

        // First push after release lands in entry 0.
        op(1'b1, 1'b0, 16'h5555, 1'b0, 1, 16'h5555, 1'b0, 1'b0);
        op(1'b1, 1'b1, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b0);
        op(1'b0, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b0);

        stack_en = 1'b0;
        for (int w = 0; w < 5 && q.size() > 0; w++)
            @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hw_stack.md
Name: hw_stack

Overview:
- LIFO data stack for the 16-bit processor, directly downstream of the instruction control decoder.
- Consumes the decoder's `stack_en` and `stack_rwb` strobes:
  - `push` opcode 4 drives en=1, rwb=0.
  - `pop` opcode 5 drives en=1, rwb=1.
- Push data is the register-file read port selected by `rf_a`.
- Pop data feeds the register-file write-data mux, input 2 (`rf_data`=2).
- The processor is single-cycle, so top-of-stack is readable combinationally and the pointer updates on the same edge as the register-file write.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 16, number of stack entries; must be a power of two, at least 2.
- AW, $clog2(DEPTH), pointer width. Derived; not to be overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- stack_en  input  1  stack operation strobe from the control decoder.
- stack_rwb  input  1  1 = pop (read), 0 = push (write); ignored when stack_en=0.
- push_data  input  WIDTH  word to push (register-file read data).
- err_clr  input  1  synchronous clear of the sticky error flags.
- pop_data  output  WIDTH  current top-of-stack word (combinational).
- sp  output  AW+1  stack pointer, equal to the number of valid entries (0..DEPTH).
- empty  output  1  sp == 0.
- full  output  1  sp == DEPTH.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - sp=0, overflow=0, underflow=0, hence empty=1, full=0, pop_data=0.
  - Memory array is not reset.
  - Reset asserted mid-operation discards any in-flight push or pop on that edge.
- Storage: DEPTH x WIDTH register array. Entry k is valid for k < sp.
- pop_data:
  - mem[sp-1] when sp > 0, else 0.
  - Purely combinational from sp and the array; no added latency.
- Push (stack_en=1, stack_rwb=0, full=0):
  - At the rising edge, mem[sp] <= push_data and sp <= sp+1.
  - pop_data shows the new word after the edge.
- Pop (stack_en=1, stack_rwb=1, empty=0):
  - Before the edge, pop_data = mem[sp-1]; the register file captures it at the edge.
  - At the edge, sp <= sp-1. The memory entry is left unchanged.
- Push while full: no write, sp unchanged, overflow <= 1.
- Pop while empty: no change to sp, pop_data stays 0, underflow <= 1.
- stack_en=0: no state change. stack_rwb is don't-care, including X.
- Flags:
  - overflow and underflow hold until err_clr=1 is seen at an edge or reset occurs.
  - If err_clr=1 coincides with a new error, the new error wins: the flag ends at 1.
- Only one operation per cycle (push or pop); there is no simultaneous push/pop.
- sp never wraps: saturating bounds are enforced by the full/empty guards above.
- Bounds are checked on registered sp only.

Test Plan:
- Reset then idle: rst_n low with stack_en=1 toggling -> sp=0, empty=1, pop_data=0, no flags.
- LIFO order: push 0x1234, 0xBEEF, 0x0001 on consecutive cycles -> sp=3, pop_data=0x0001. Then three pops -> pop_data before each edge is 0x0001, 0xBEEF, 0x1234. Finally sp=0, empty=1.
- Fill boundary: 16 pushes of 0x0000..0x000F -> full=1, sp=16. 17th push of 0xFFFF -> sp stays 16, overflow=1, pop_data=0x000F.
- Underflow: pop on empty stack -> sp=0, pop_data=0, underflow=1. Then err_clr=1 for one cycle -> underflow=0. err_clr concurrent with another empty pop -> underflow stays 1.
- Interleaved: push A, pop, push B, push C, pop -> pop_data after the sequence is B, sp=1. Idle cycles with stack_en=0 and stack_rwb=X leave state unchanged.
- Async reset mid-stream: sp=5, assert rst_n low between edges -> sp=0 and pop_data=0 immediately, without waiting for a clock edge. A push at the next edge after release writes entry 0.
